// File: rtl/re_retime_pkg.sv
// Shared types, default sizing and helpers for the multi-channel retiming buffer.
package re_retime_pkg;

    localparam int RE_WIDTH_DATA  = 32;
    localparam int RE_NUM_CHANNEL = 2;
    localparam int RE_DEPTH_FIFO  = 16;
    localparam int RE_WIDTH_DELAY = $clog2(RE_DEPTH_FIFO);

    typedef logic [RE_WIDTH_DATA-1:0]                data_t;
    typedef logic [RE_NUM_CHANNEL-1:0]               ch_vec_t;
    typedef logic [RE_NUM_CHANNEL*RE_WIDTH_DATA-1:0] ch_data_t;
    typedef logic [RE_WIDTH_DELAY-1:0]               delay_t;

    localparam delay_t RE_DEF_DELAY = '0;

    // Channel-select width never collapses to zero bits, even for one channel.
    function automatic int ch_sel_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/re_delay_fifo.sv
// One retiming channel: token FIFO whose head is released once its age reaches
// the channel's programmable delay. Full nacks upstream without crediting a same-cycle pop.
module re_delay_fifo
    import re_retime_pkg::*;
#(
    parameter int                     WIDTH_DATA  = RE_WIDTH_DATA,
    parameter int                     DEPTH_FIFO  = RE_DEPTH_FIFO,
    parameter int                     WIDTH_DELAY = $clog2(DEPTH_FIFO),
    parameter logic [WIDTH_DELAY-1:0] DEF_DELAY   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_v,
    input  logic [WIDTH_DATA-1:0]  in_d,
    output logic                   in_nack,
    output logic                   out_v,
    output logic [WIDTH_DATA-1:0]  out_d,
    input  logic                   out_nack,
    input  logic                   cfg_we,
    input  logic [WIDTH_DELAY-1:0] cfg_dly,
    output logic                   empty
);

    localparam int WIDTH_PTR = WIDTH_DELAY + 1;

    logic [WIDTH_PTR-1:0]   wr_ptr;
    logic [WIDTH_PTR-1:0]   rd_ptr;
    logic [WIDTH_DELAY-1:0] wr_idx;
    logic [WIDTH_DELAY-1:0] rd_idx;
    logic [WIDTH_DATA-1:0]  mem [DEPTH_FIFO];
    logic [WIDTH_DELAY-1:0] age [DEPTH_FIFO];
    logic [WIDTH_DELAY-1:0] delay_q;
    logic                   full;
    logic                   push;
    logic                   pop;

    assign wr_idx = wr_ptr[WIDTH_DELAY-1:0];
    assign rd_idx = rd_ptr[WIDTH_DELAY-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[WIDTH_DELAY] != rd_ptr[WIDTH_DELAY]) && (wr_idx == rd_idx);

    assign in_nack = full;
    assign push    = in_v && !full;
    assign out_v   = !empty && (age[rd_idx] >= delay_q);
    assign out_d   = empty ? '0 : mem[rd_idx];
    assign pop     = out_v && !out_nack;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            delay_q <= DEF_DELAY;
        end else begin
            if (push)   wr_ptr  <= wr_ptr + 1'b1;
            if (pop)    rd_ptr  <= rd_ptr + 1'b1;
            if (cfg_we) delay_q <= cfg_dly;
        end
    end

    // Free slots age too; the count is cleared when a token lands in the slot.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH_FIFO; i++) begin
            if (reset) begin
                age[i] <= '0;
            end else if (push && (wr_idx == i[WIDTH_DELAY-1:0])) begin
                age[i] <= '0;
            end else if (age[i] != '1) begin
                age[i] <= age[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_idx] <= in_d;
    end

endmodule

// File: rtl/re_retime_buffer.sv
// Multi-channel retiming unit: NUM_CHANNEL independent delay FIFOs plus the
// runtime delay-configuration port with its rejection pulse.
module re_retime_buffer
    import re_retime_pkg::*;
#(
    parameter int  WIDTH_DATA  = RE_WIDTH_DATA,
    parameter int  NUM_CHANNEL = RE_NUM_CHANNEL,
    parameter int  DEPTH_FIFO  = RE_DEPTH_FIFO,
    parameter int  WIDTH_DELAY = $clog2(DEPTH_FIFO),
    parameter int  DEF_DELAY   = int'(RE_DEF_DELAY),
    localparam int WIDTH_CH    = ch_sel_width(NUM_CHANNEL)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CHANNEL-1:0]            I_FTk_v,
    input  logic [NUM_CHANNEL*WIDTH_DATA-1:0] I_FTk_d,
    output logic [NUM_CHANNEL-1:0]            O_BTk_n,
    output logic [NUM_CHANNEL-1:0]            O_FTk_v,
    output logic [NUM_CHANNEL*WIDTH_DATA-1:0] O_FTk_d,
    input  logic [NUM_CHANNEL-1:0]            I_BTk_n,
    input  logic                              I_Cfg_v,
    input  logic [WIDTH_CH-1:0]               I_Cfg_ch,
    input  logic [WIDTH_DELAY-1:0]            I_Cfg_dly,
    output logic                              O_Cfg_err,
    output logic [NUM_CHANNEL-1:0]            O_Empty
);

    logic [NUM_CHANNEL-1:0] push;
    logic [NUM_CHANNEL-1:0] empty;
    logic [NUM_CHANNEL-1:0] cfg_we;
    logic                   cfg_err_q;

    assign push = I_FTk_v & ~O_BTk_n;

    // A delay may only change while the channel is idle, so no stored token
    // ever sees a delay other than the one it was pushed under.
    always_comb begin
        cfg_we = '0;
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            if (I_Cfg_v && (I_Cfg_ch == WIDTH_CH'(c)) && empty[c] && !push[c]) begin
                cfg_we[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= I_Cfg_v && (cfg_we == '0);
        end
    end

    assign O_Cfg_err = cfg_err_q;
    assign O_Empty   = empty;

    for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_ch
        re_delay_fifo #(
            .WIDTH_DATA  (WIDTH_DATA),
            .DEPTH_FIFO  (DEPTH_FIFO),
            .WIDTH_DELAY (WIDTH_DELAY),
            .DEF_DELAY   (WIDTH_DELAY'(DEF_DELAY))
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .in_v     (I_FTk_v[c]),
            .in_d     (I_FTk_d[c*WIDTH_DATA +: WIDTH_DATA]),
            .in_nack  (O_BTk_n[c]),
            .out_v    (O_FTk_v[c]),
            .out_d    (O_FTk_d[c*WIDTH_DATA +: WIDTH_DATA]),
            .out_nack (I_BTk_n[c]),
            .cfg_we   (cfg_we[c]),
            .cfg_dly  (I_Cfg_dly),
            .empty    (empty[c])
        );
    end

endmodule

// File: tb/tb_re_retime_buffer.sv
// Self-checking bench for re_retime_buffer: directed scenarios plus random traffic
// against a queue-based model that tracks each token's push time.
module tb_re_retime_buffer;
    import re_retime_pkg::*;

    localparam int NCH   = RE_NUM_CHANNEL;
    localparam int WD    = RE_WIDTH_DATA;
    localparam int DEPTH = RE_DEPTH_FIFO;
    localparam int WDLY  = RE_WIDTH_DELAY;
    localparam int WCH   = ch_sel_width(NCH);
    localparam int WALL  = 3*NCH + 1 + NCH*WD;

    logic            clock = 1'b0;
    logic            reset;
    ch_vec_t         I_FTk_v, O_BTk_n, O_FTk_v, I_BTk_n, O_Empty;
    ch_data_t        I_FTk_d, O_FTk_d;
    logic            I_Cfg_v;
    logic [WCH-1:0]  I_Cfg_ch;
    delay_t          I_Cfg_dly;
    logic            O_Cfg_err;
    logic [WALL-1:0] obs_all;

    always #5 clock = ~clock;

    re_retime_buffer #(
        .WIDTH_DATA (WD), .NUM_CHANNEL (NCH), .DEPTH_FIFO (DEPTH),
        .WIDTH_DELAY (WDLY), .DEF_DELAY (int'(RE_DEF_DELAY))
    ) dut (
        .clock (clock), .reset (reset),
        .I_FTk_v (I_FTk_v), .I_FTk_d (I_FTk_d), .O_BTk_n (O_BTk_n),
        .O_FTk_v (O_FTk_v), .O_FTk_d (O_FTk_d), .I_BTk_n (I_BTk_n),
        .I_Cfg_v (I_Cfg_v), .I_Cfg_ch (I_Cfg_ch), .I_Cfg_dly (I_Cfg_dly),
        .O_Cfg_err (O_Cfg_err), .O_Empty (O_Empty)
    );

    assign obs_all = {O_FTk_v, O_BTk_n, O_Empty, O_Cfg_err, O_FTk_d};

    // Model: a token is visible once (now - push edge) reaches the channel delay.
    typedef struct { data_t d; int t; } tok_t;
    tok_t mq [NCH][$];
    int   m_dly [NCH];
    logic m_err;
    int   cyc;
    int   checks;
    int   errors;

    function automatic logic [WALL-1:0] exp_all();
        ch_vec_t  v, n, e;
        ch_data_t d;
        v = '0; n = '0; e = '0; d = '0;
        for (int c = 0; c < NCH; c++) begin
            e[c] = (mq[c].size() == 0);
            n[c] = (mq[c].size() == DEPTH);
            if (!e[c]) begin
                v[c] = (cyc - mq[c][0].t) >= m_dly[c];
                d[c*WD +: WD] = mq[c][0].d;
            end
        end
        return {v, n, e, m_err, d};
    endfunction

    task automatic tick();
        ch_vec_t pu, po;
        logic    acc;
        int      ch;
        tok_t    tk;
        for (int c = 0; c < NCH; c++) begin
            pu[c] = I_FTk_v[c] && (mq[c].size() < DEPTH);
            po[c] = (mq[c].size() > 0) && ((cyc - mq[c][0].t) >= m_dly[c]) && !I_BTk_n[c];
        end
        ch  = int'(I_Cfg_ch);
        acc = 1'b0;
        if (I_Cfg_v && ch < NCH) acc = (mq[ch].size() == 0) && !pu[ch];
        @(posedge clock);
        cyc++;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                mq[c].delete();
                m_dly[c] = int'(RE_DEF_DELAY);
            end
            m_err = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (po[c]) void'(mq[c].pop_front());
                if (pu[c]) begin
                    tk.d = I_FTk_d[c*WD +: WD];
                    tk.t = cyc;
                    mq[c].push_back(tk);
                end
            end
            m_err = I_Cfg_v && !acc;
            if (acc) m_dly[ch] = int'(I_Cfg_dly);
        end
        #1;
    endtask

    task automatic set_idle();
        I_FTk_v = '0; I_FTk_d = '0; I_BTk_n = '0;
        I_Cfg_v = 1'b0; I_Cfg_ch = '0; I_Cfg_dly = '0;
    endtask

    task automatic cfg_write(input int ch, input int dly);
        I_Cfg_v = 1'b1; I_Cfg_ch = WCH'(ch); I_Cfg_dly = delay_t'(dly);
        tick();
        I_Cfg_v = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (O_FTk_v !== '0) begin errors++; $display("FAIL reset_v: got %b want 00", O_FTk_v); end
        checks++;
        if (O_Empty !== 2'b11) begin errors++; $display("FAIL reset_empty: got %b want 11", O_Empty); end
        checks++;
        if (O_BTk_n !== '0 || O_Cfg_err !== 1'b0) begin
            errors++; $display("FAIL reset_nack_err: got %b/%b want 00/0", O_BTk_n, O_Cfg_err);
        end
        checks++;
        if (O_FTk_d !== '0) begin errors++; $display("FAIL reset_d: got %h want 0", O_FTk_d); end
    endtask

    task automatic test_latency();
        int n;
        cfg_write(0, 3);
        checks++;
        if (O_Cfg_err !== 1'b0) begin errors++; $display("FAIL lat_cfg_err: got %b want 0", O_Cfg_err); end
        I_FTk_v = 2'b01; I_FTk_d[WD-1:0] = 32'hA5;
        tick();
        I_FTk_v = '0;
        n = 0;
        while (!O_FTk_v[0] && n < 30) begin
            checks++;
            if (obs_all !== exp_all()) begin errors++; $display("FAIL lat_model: got %h want %h", obs_all, exp_all()); end
            tick(); n++;
        end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL lat_cycles: got %0d want 3", n); end
        checks++;
        if (O_FTk_d[WD-1:0] !== 32'hA5) begin errors++; $display("FAIL lat_data: got %h want a5", O_FTk_d[WD-1:0]); end
        tick();
        checks++;
        if (O_Empty[0] !== 1'b1) begin errors++; $display("FAIL lat_pop: got %b want 1", O_Empty[0]); end
    endtask

    task automatic test_stream();
        data_t got[$];
        cfg_write(1, 0);
        for (int i = 0; i <= 20; i++) begin
            I_FTk_v = (i < 20) ? 2'b10 : 2'b00;
            I_FTk_d[WD +: WD] = data_t'(i);
            if (O_FTk_v[1]) got.push_back(O_FTk_d[WD +: WD]);
            tick();
            checks++;
            if (obs_all !== exp_all()) begin errors++; $display("FAIL stream_model: got %h want %h", obs_all, exp_all()); end
            if (i < 20) begin
                checks++;
                if (O_FTk_v[1] !== 1'b1 || O_FTk_d[WD +: WD] !== data_t'(i)) begin
                    errors++; $display("FAIL stream_out: got v=%b d=%0d want v=1 d=%0d", O_FTk_v[1], O_FTk_d[WD +: WD], i);
                end
            end
        end
        checks++;
        if (got.size() !== 20) begin errors++; $display("FAIL stream_count: got %0d want 20", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== data_t'(i)) begin errors++; $display("FAIL stream_order: got %0d want %0d", got[i], i); end
        end
        checks++;
        if (O_Empty[1] !== 1'b1) begin errors++; $display("FAIL stream_drain: got %b want 1", O_Empty[1]); end
    endtask

    task automatic test_full();
        data_t sent[$], got[$];
        int    n;
        logic  pre;
        cfg_write(0, 0);
        I_BTk_n = 2'b01;
        for (int i = 0; i < 17; i++) sent.push_back(data_t'($urandom));
        for (int i = 0; i < 16; i++) begin
            I_FTk_v[0] = 1'b1; I_FTk_d[WD-1:0] = sent[i];
            tick();
            checks++;
            if (obs_all !== exp_all()) begin errors++; $display("FAIL fill_model: got %h want %h", obs_all, exp_all()); end
        end
        checks++;
        if (O_BTk_n[0] !== 1'b1) begin errors++; $display("FAIL full_nack: got %b want 1", O_BTk_n[0]); end
        I_FTk_d[WD-1:0] = sent[16];
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({O_BTk_n[0], O_FTk_v[0], O_FTk_d[WD-1:0]} !== {1'b1, 1'b1, sent[0]}) begin
                errors++; $display("FAIL stall_head: got n=%b v=%b d=%h want n=1 v=1 d=%h",
                                   O_BTk_n[0], O_FTk_v[0], O_FTk_d[WD-1:0], sent[0]);
            end
        end
        I_BTk_n = '0;
        n = 0;
        while (got.size() < 17 && n < 60) begin
            pre = O_BTk_n[0];
            if (O_FTk_v[0]) got.push_back(O_FTk_d[WD-1:0]);
            tick(); n++;
            if (!pre) I_FTk_v[0] = 1'b0;
            checks++;
            if (obs_all !== exp_all()) begin errors++; $display("FAIL drain_model: got %h want %h", obs_all, exp_all()); end
        end
        checks++;
        if (got.size() !== 17) begin errors++; $display("FAIL full_count: got %0d want 17", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== sent[i]) begin errors++; $display("FAIL full_order: got %h want %h", got[i], sent[i]); end
        end
        I_FTk_v = '0;
    endtask

    task automatic test_saturate();
        data_t x;
        x = data_t'($urandom);
        cfg_write(0, 15);
        I_BTk_n = 2'b01;
        I_FTk_v = 2'b01; I_FTk_d[WD-1:0] = x;
        tick();
        I_FTk_v = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs_all !== exp_all()) begin errors++; $display("FAIL sat_model: got %h want %h", obs_all, exp_all()); end
        end
        checks++;
        if (O_FTk_v[0] !== 1'b1 || O_FTk_d[WD-1:0] !== x) begin
            errors++; $display("FAIL sat_hold: got v=%b d=%h want v=1 d=%h", O_FTk_v[0], O_FTk_d[WD-1:0], x);
        end
        I_BTk_n = '0;
        tick();
        checks++;
        if (O_Empty[0] !== 1'b1) begin errors++; $display("FAIL sat_release: got %b want 1", O_Empty[0]); end
    endtask

    task automatic test_cfg_err();
        int n;
        I_BTk_n = 2'b01;
        I_FTk_v = 2'b01; I_FTk_d[WD-1:0] = data_t'($urandom);
        tick();
        I_FTk_v = '0;
        cfg_write(0, 2);
        checks++;
        if (O_Cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_busy_err: got %b want 1", O_Cfg_err); end
        tick();
        checks++;
        if (O_Cfg_err !== 1'b0 || O_FTk_v[0] !== 1'b0) begin
            errors++; $display("FAIL cfg_busy_after: got err=%b v=%b want err=0 v=0", O_Cfg_err, O_FTk_v[0]);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (obs_all !== exp_all()) begin errors++; $display("FAIL cfg_keep_model: got %h want %h", obs_all, exp_all()); end
        end
        checks++;
        if (O_FTk_v[0] !== 1'b1) begin errors++; $display("FAIL cfg_keep_rel: got %b want 1", O_FTk_v[0]); end
        I_BTk_n = '0;
        tick();
        cfg_write(1, 5);
        checks++;
        if (O_Cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_ok_err: got %b want 0", O_Cfg_err); end
        I_FTk_v = 2'b10; I_FTk_d[WD +: WD] = 32'h5A5A_0001;
        tick();
        I_FTk_v = '0;
        n = 0;
        while (!O_FTk_v[1] && n < 30) begin tick(); n++; end
        checks++;
        if (n !== 5 || O_FTk_d[WD +: WD] !== 32'h5A5A_0001) begin
            errors++; $display("FAIL cfg_new_lat: got %0d d=%h want 5 d=5a5a0001", n, O_FTk_d[WD +: WD]);
        end
        tick();
        I_Cfg_v = 1'b1; I_Cfg_ch = WCH'(1); I_Cfg_dly = delay_t'(9);
        I_FTk_v = 2'b10; I_FTk_d[WD +: WD] = data_t'($urandom);
        tick();
        I_Cfg_v = 1'b0; I_FTk_v = '0;
        checks++;
        if (O_Cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_push_err: got %b want 1", O_Cfg_err); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs_all !== exp_all()) begin errors++; $display("FAIL cfg_push_model: got %h want %h", obs_all, exp_all()); end
        end
    endtask

    task automatic test_reset_mid();
        I_BTk_n = 2'b11;
        for (int i = 0; i < 6; i++) begin
            I_FTk_v = 2'b11; I_FTk_d = {$urandom, $urandom};
            tick();
        end
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0; I_FTk_v = '0; I_BTk_n = '0;
        checks++;
        if (O_FTk_v !== '0 || O_Empty !== 2'b11) begin
            errors++; $display("FAIL mid_reset: got v=%b e=%b want v=00 e=11", O_FTk_v, O_Empty);
        end
        checks++;
        if (O_BTk_n !== '0 || O_FTk_d !== '0) begin
            errors++; $display("FAIL mid_reset_nd: got n=%b d=%h want n=00 d=0", O_BTk_n, O_FTk_d);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            I_FTk_v   = ch_vec_t'($urandom_range(0, 3));
            I_FTk_d   = {$urandom, $urandom};
            for (int c = 0; c < NCH; c++) I_BTk_n[c] = ($urandom_range(0, 9) < 3);
            I_Cfg_v   = ($urandom_range(0, 19) == 0);
            I_Cfg_ch  = WCH'($urandom_range(0, NCH - 1));
            I_Cfg_dly = ($urandom_range(0, 3) == 0) ? delay_t'($urandom_range(0, 15))
                                                   : delay_t'($urandom_range(0, 2));
            reset     = ($urandom_range(0, 599) == 0);
            tick();
            checks++;
            if (obs_all !== exp_all()) begin errors++; $display("FAIL random_model: cyc %0d got %h want %h", cyc, obs_all, exp_all()); end
        end
        reset = 1'b0;
        set_idle();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; m_err = 1'b0;
        for (int c = 0; c < NCH; c++) m_dly[c] = int'(RE_DEF_DELAY);
        reset = 1'b1;
        set_idle();
        #1;
        test_reset();
        test_latency();
        test_stream();
        test_full();
        test_saturate();
        test_cfg_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
